axil_master_cmd: RTL and testbench
==================================

Name: axil_master_cmd

Overview:
- AXI4-Lite master sequencer that sits directly upstream of the register-file AXI slave in the self-test and bring-up path.
- Converts single-beat commands (read or write, address, data) from a simple valid/ready command port into complete AXI4-Lite transactions.
- Returns read data and response code on a response port, one command in flight at a time.
- Includes a per-transaction timeout so a hung slave cannot lock the test harness.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, data bus width in bits.
- C_M_AXI_ADDR_WIDTH, 8, address bus width in bits.
- TIMEOUT_CYCLES, 256, cycles allowed per transaction from command accept to response. Must be ≥16.

Ports:
- M_AXI_ACLK  in  1  clock; all logic on rising edge.
- M_AXI_ARESET  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP captured from the slave.
- rsp_timeout  out  1  transaction aborted by timeout.
- M_AXI_AWADDR  out  ADDR_WIDTH  write address.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  DATA_WIDTH  write data.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- M_AXI_ARADDR  out  ADDR_WIDTH  read address.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  DATA_WIDTH  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.

Behaviour:
- Reset values:
  - All VALID and READY outputs 0, except cmd_ready = 1.
  - AWADDR, WDATA, ARADDR, rsp_rdata, rsp_resp and rsp_timeout are 0.
  - State is IDLE; timeout counter is 0.
  - Reset mid-transaction aborts immediately with no response.
- State machine: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register addr and wdata onto the AXI outputs and clear the counter.
  - Go to WR_REQ if cmd_write = 1, else RD_REQ.
  - cmd_ready drops the cycle after accept.
- WR_REQ:
  - AWVALID and WVALID assert together, the cycle after accept.
  - Each deasserts independently on its own handshake (VALID & READY); aw_done and w_done flags are tracked.
  - Go to WR_RESP when both are done, including the case where both complete in the same cycle.
  - Also handles a slave that raises WREADY only after AW completes.
- WR_RESP:
  - BREADY held 1 for the whole state.
  - On BVALID, capture BRESP into rsp_resp, set rsp_rdata = 0, go to RSP.
- RD_REQ: ARVALID = 1 until the ARREADY handshake, then go to RD_RESP.
- RD_RESP:
  - RREADY held 1 for the whole state.
  - On RVALID, capture RDATA and RRESP, go to RSP.
  - A single-cycle RVALID or BVALID pulse must be captured.
- Address and data stability:
  - AWADDR, WDATA and ARADDR remain stable from accept until the block returns to IDLE, not just until their handshake.
  - The slave samples the address after its READY pulse, so this is mandatory.
- RSP:
  - rsp_valid = 1, all response fields stable.
  - Leave to IDLE when rsp_ready = 1; cmd_ready = 1 the following cycle.
  - A command asserted during RSP waits.
- Timeout:
  - Counter increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When it reaches TIMEOUT_CYCLES-1, drop all AXI VALID/READY outputs and go to RSP with rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 0.
  - rsp_timeout clears on the next accepted command.
  - Timeout abort is a debug recovery path only; the slave must be reset afterwards.
- Minimum latency: accept to rsp_valid is 3 cycles when READY/VALID from the slave are immediate. No pipelining; one outstanding transaction.
- Widths: all address and data paths pass through unmodified. The counter is $clog2(TIMEOUT_CYCLES)+1 bits and saturates, never wrapping.

Test Plan:
- Write addr 0x04, data 0xDEADBEEF against the register-file slave:
  - AWADDR stays 0x04 until return to IDLE.
  - rsp_valid with rsp_resp = 00, rsp_timeout = 0.
- Read back 0x04 → rsp_rdata = 0xDEADBEEF, rsp_resp = 00.
- Write 0x84 = 0x5, then read 0x84 → rsp_rdata = 0x00000005 (config area).
- Slave model with AWREADY/WREADY both in the same cycle, and with WREADY 5 cycles before AWREADY → exactly one AW and one W handshake each, single response.
- Slave never asserts ARREADY, TIMEOUT_CYCLES = 16 → rsp_valid on cycle 16 after accept, rsp_timeout = 1, rsp_resp = 10, ARVALID = 0.
- Hold rsp_ready = 0 for 10 cycles with cmd_valid = 1 → cmd_ready stays 0 and response fields stay stable. Assert M_AXI_ARESET mid-WR_REQ → next cycle all VALIDs = 0, cmd_ready = 1.

Source files
------------

// File: rtl/axil_master_cmd.sv
// Single-outstanding AXI4-Lite master: turns valid/ready read/write commands into AXI transactions.
// Latency is 3 cycles from accept to rsp_valid against an immediate slave; a hung slave is aborted after TIMEOUT_CYCLES.
module axil_master_cmd #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    // Abort on the edge where the count reaches TIMEOUT_CYCLES-1, so the
    // response appears TIMEOUT_CYCLES cycles after accept. AXI handshakes
    // are suppressed in that final cycle so none is half-taken.
    localparam logic [CW-1:0] TO_ARM = CW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP
    } state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            aw_done_q, aw_done_d;
    logic                            w_done_q, w_done_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                      resp_q, resp_d;
    logic                            timeout_q, timeout_d;
    logic                            busy;
    logic                            to_hit;

    assign busy   = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                    (state_q == RD_REQ) || (state_q == RD_RESP);
    assign to_hit = busy && (cnt_q == TO_ARM);

    assign M_AXI_AWADDR = awaddr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_ARADDR = araddr_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;
    assign rsp_timeout  = timeout_q;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        resp_d        = resp_q;
        timeout_d     = timeout_q;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;

        if (busy && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (cmd_write) begin
                        awaddr_d = cmd_addr;
                        wdata_d  = cmd_wdata;
                        state_d  = WR_REQ;
                    end else begin
                        araddr_d = cmd_addr;
                        state_d  = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                M_AXI_AWVALID = !aw_done_q && !to_hit;
                M_AXI_WVALID  = !w_done_q && !to_hit;
                aw_done_d     = aw_done_q || (M_AXI_AWVALID && M_AXI_AWREADY);
                w_done_d      = w_done_q || (M_AXI_WVALID && M_AXI_WREADY);
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                M_AXI_BREADY = !to_hit;
                if (M_AXI_BVALID && M_AXI_BREADY) begin
                    resp_d  = M_AXI_BRESP;
                    rdata_d = '0;
                    state_d = RSP;
                end
            end
            RD_REQ: begin
                M_AXI_ARVALID = !to_hit;
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                M_AXI_RREADY = !to_hit;
                if (M_AXI_RVALID && M_AXI_RREADY) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (to_hit) begin
            state_d   = RSP;
            timeout_d = 1'b1;
            resp_d    = 2'b10;
            rdata_d   = '0;
        end
    end

endmodule

// File: tb/tb_axil_master_cmd.sv
// Directed bench for axil_master_cmd against a small register-file slave with programmable ready delays.
module tb_axil_master_cmd;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [1:0]    bresp, rresp;

    int tests = 0;
    int fails = 0;

    // Slave behaviour knobs
    int aw_lat = 0, w_lat = 0;
    bit ar_block = 1'b0;
    int aw_wait, w_wait;
    logic aw_got, w_got;
    logic [DW-1:0] mem [64];
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;

    always #5 clk = ~clk;

    axil_master_cmd #(
        .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    assign awready = awvalid && !aw_got && (aw_wait >= aw_lat);
    assign wready  = wvalid && !w_got && (w_wait >= w_lat);
    assign arready = arvalid && !ar_block;

    // Addresses 0xC0..0xFF answer SLVERR
    always @(posedge clk) begin
        if (arst) begin
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00;
            rdata <= '0; aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            if (awvalid && !awready) aw_wait <= aw_wait + 1;
            if (awvalid && awready) begin aw_got <= 1'b1; aw_wait <= 0; aw_hs <= aw_hs + 1; end
            if (wvalid && !wready) w_wait <= w_wait + 1;
            if (wvalid && wready) begin w_got <= 1'b1; w_wait <= 0; w_hs <= w_hs + 1; end
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                mem[awaddr[7:2]] <= wdata;
                bresp  <= (awaddr[7:6] == 2'b11) ? 2'b10 : 2'b00;
                bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (bvalid && bready) begin bvalid <= 1'b0; b_hs <= b_hs + 1; end
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= mem[araddr[7:2]];
                rresp  <= (araddr[7:6] == 2'b11) ? 2'b10 : 2'b00;
                ar_hs  <= ar_hs + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command and returns at a negedge inside RSP with rsp_ready still low.
    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           output int lat, output bit addr_ok);
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        guard = 0;
        while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        lat = 0;
        addr_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (wr) addr_ok &= (awaddr === addr) && (wdata === data);
            else    addr_ok &= (araddr === addr);
        end while (!rsp_valid && lat < 200);
    endtask

    task automatic release_rsp;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  ok;
        int  a0, w0, b0, r0;
        bit  stable;

        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_handshakes", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        check("reset_fields", {awaddr, wdata, araddr, rsp_rdata, rsp_resp, rsp_timeout}, 0);
        @(negedge clk); arst = 1'b0;

        // Write 0x04 = DEADBEEF, immediate slave
        a0 = aw_hs; w0 = w_hs; b0 = b_hs;
        run_cmd(1'b1, 8'h04, 32'hDEADBEEF, lat, ok);
        check("wr04_latency", lat, 3);
        check("wr04_addr_stable", ok, 1);
        check("wr04_rsp", {rsp_resp, rsp_timeout, rsp_rdata}, 0);
        check("wr04_hs", {8'(aw_hs - a0), 8'(w_hs - w0), 8'(b_hs - b0)}, 24'h010101);
        release_rsp();
        check("wr04_cmd_ready_after", cmd_ready, 1);

        run_cmd(1'b0, 8'h04, 32'h0, lat, ok);
        check("rd04_latency", lat, 3);
        check("rd04_addr_stable", ok, 1);
        check("rd04_data", rsp_rdata, 32'hDEADBEEF);
        check("rd04_resp", {rsp_resp, rsp_timeout}, 0);
        release_rsp();

        run_cmd(1'b1, 8'h84, 32'h5, lat, ok);
        release_rsp();
        run_cmd(1'b0, 8'h84, 32'h0, lat, ok);
        check("rd84_data", rsp_rdata, 32'h00000005);
        release_rsp();

        // WREADY 5 cycles ahead of AWREADY
        aw_lat = 5; w_lat = 0;
        a0 = aw_hs; w0 = w_hs; b0 = b_hs;
        run_cmd(1'b1, 8'h10, 32'h12345678, lat, ok);
        check("wr_awlate_latency", lat, 8);
        check("wr_awlate_addr_stable", ok, 1);
        check("wr_awlate_hs", {8'(aw_hs - a0), 8'(w_hs - w0), 8'(b_hs - b0)}, 24'h010101);
        release_rsp();

        // WREADY only after AW completes
        aw_lat = 0; w_lat = 5;
        a0 = aw_hs; w0 = w_hs; b0 = b_hs;
        run_cmd(1'b1, 8'h14, 32'hA5A5_0F0F, lat, ok);
        check("wr_wlate_latency", lat, 8);
        check("wr_wlate_hs", {8'(aw_hs - a0), 8'(w_hs - w0), 8'(b_hs - b0)}, 24'h010101);
        release_rsp();
        w_lat = 0;
        run_cmd(1'b0, 8'h10, 32'h0, lat, ok);
        check("rd10_data", rsp_rdata, 32'h12345678);
        release_rsp();
        run_cmd(1'b0, 8'h14, 32'h0, lat, ok);
        check("rd14_data", rsp_rdata, 32'hA5A50F0F);
        release_rsp();

        // Slave error response is passed through
        run_cmd(1'b1, 8'hC0, 32'h0000_BEEF, lat, ok);
        check("wrC0_resp", {rsp_resp, rsp_timeout}, 3'b100);
        release_rsp();
        run_cmd(1'b0, 8'hC0, 32'h0, lat, ok);
        check("rdC0_resp_data", {rsp_resp, rsp_timeout, rsp_rdata}, {3'b100, 32'h0000BEEF});
        release_rsp();

        // Hung slave: ARREADY never rises
        ar_block = 1'b1;
        r0 = ar_hs;
        run_cmd(1'b0, 8'h20, 32'h0, lat, ok);
        check("to_latency", lat, 16);
        check("to_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, {3'b110, 32'h0});
        check("to_axi_quiet", {arvalid, rready, awvalid, wvalid, bready}, 0);
        check("to_no_ar_hs", ar_hs - r0, 0);
        release_rsp();
        ar_block = 1'b0;
        run_cmd(1'b0, 8'h04, 32'h0, lat, ok);
        check("after_to_clear", {rsp_timeout, rsp_resp, rsp_rdata}, {3'b000, 32'hDEADBEEF});
        release_rsp();

        // Response backpressure with a pending command
        run_cmd(1'b0, 8'h84, 32'h0, lat, ok);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h08; cmd_wdata = 32'h77;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            stable &= (cmd_ready === 1'b0) && (rsp_valid === 1'b1) && (rsp_rdata === 32'h5) &&
                      (rsp_resp === 2'b00) && (rsp_timeout === 1'b0);
        end
        check("bp_stable", stable, 1);
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        release_rsp();
        check("bp_cmd_ready_after", cmd_ready, 1);

        // Reset in the middle of WR_REQ
        aw_lat = 20; w_lat = 20;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 32'h99;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_wr_valids", {awvalid, wvalid, cmd_ready}, 3'b110);
        arst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        arst = 1'b0; aw_lat = 0; w_lat = 0;

        run_cmd(1'b0, 8'h04, 32'h0, lat, ok);
        check("post_rst_read", {rsp_timeout, rsp_resp, rsp_rdata}, {3'b000, 32'hDEADBEEF});
        check("post_rst_latency", lat, 3);
        release_rsp();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
